// File: rtl/ahb_to_apb_bridge_mp.sv
// ahb_to_apb_bridge_mp: AHB-Lite slave to multi-slave APB3 master bridge with wait states and error mapping.
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without PREADY.
module ahb_to_apb_bridge_mp #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SLAVE_AW       = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             HCLK,
  input  logic                             HRESETn,
  input  logic                             HSEL,
  input  logic [ADDR_WIDTH-1:0]            HADDR,
  input  logic [1:0]                       HTRANS,
  input  logic                             HWRITE,
  input  logic [DATA_WIDTH-1:0]            HWDATA,
  input  logic                             HREADY,
  output logic                             HREADY_OUT,
  output logic [1:0]                       HRESP,
  output logic [DATA_WIDTH-1:0]            HRDATA,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);
  localparam int IDX_W = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  localparam logic [31:0] NS = NUM_SLAVES;
  typedef enum logic [2:0] {IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2} state_t;
  state_t state, state_d;
  logic [IDX_W-1:0] idx, idx_d, a_idx;
  logic [ADDR_WIDTH-1:0] addr, addr_d, paddr_d;
  logic write, write_d, hready_d, penable_d, pwrite_d, sel_ready, sel_err, accept, expired;
  logic [1:0] hresp_d;
  logic [DATA_WIDTH-1:0] hrdata_d, pwdata_d;
  logic [NUM_SLAVES-1:0] psel_d;
  assign a_idx = HADDR[SLAVE_AW +: IDX_W];
  assign accept = HSEL && HREADY && (HTRANS inside {2'b10, 2'b11});
  assign sel_ready = PREADY[idx];
  assign sel_err = PSLVERR[idx];
`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign expired = cnt == CW'(TIMEOUT_CYCLES - 1);
  // count not-ready ACCESS cycles, cleared as the transfer enters ACCESS
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) cnt <= '0;
    else if (state == SETUP) cnt <= '0;
    else if (state == ACCESS && !sel_ready) cnt <= cnt + 1'b1;
`else
  assign expired = 1'b0;
`endif
  // next-state and next-output decode; every output is a register
  always_comb begin
    state_d = state;
    idx_d = idx;
    addr_d = addr;
    write_d = write;
    hready_d = HREADY_OUT;
    hresp_d = HRESP;
    hrdata_d = HRDATA;
    psel_d = PSEL;
    penable_d = PENABLE;
    paddr_d = PADDR;
    pwrite_d = PWRITE;
    pwdata_d = PWDATA;
    case (state)
      IDLE: if (accept) begin
        addr_d = HADDR;
        write_d = HWRITE;
        idx_d = a_idx;
        hready_d = 1'b0;
        state_d = {1'b0, a_idx} < NS[IDX_W:0] ? LATCH : ERR1;
        hresp_d = {1'b0, a_idx} < NS[IDX_W:0] ? 2'b00 : 2'b01;
      end
      LATCH: begin
        pwdata_d = write ? HWDATA : PWDATA;
        paddr_d = addr;
        pwrite_d = write;
        psel_d = NUM_SLAVES'(1) << idx;
        state_d = SETUP;
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: if (sel_ready || expired) begin
        psel_d = '0;
        penable_d = 1'b0;
        state_d = (sel_ready && !sel_err) ? IDLE : ERR1;
        hresp_d = (sel_ready && !sel_err) ? 2'b00 : 2'b01;
        hready_d = sel_ready && !sel_err;
        hrdata_d = (sel_ready && !sel_err && !write) ? PRDATA[idx*DATA_WIDTH +: DATA_WIDTH] : HRDATA;
      end
      ERR1: begin
        hready_d = 1'b1;
        state_d = ERR2;
      end
      ERR2: begin
        hresp_d = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers with asynchronous reset
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state <= IDLE;
      idx <= '0;
      addr <= '0;
      write <= 1'b0;
      HREADY_OUT <= 1'b1;
      HRESP <= 2'b00;
      HRDATA <= '0;
      PSEL <= '0;
      PENABLE <= 1'b0;
      PADDR <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
    end else begin
      state <= state_d;
      idx <= idx_d;
      addr <= addr_d;
      write <= write_d;
      HREADY_OUT <= hready_d;
      HRESP <= hresp_d;
      HRDATA <= hrdata_d;
      PSEL <= psel_d;
      PENABLE <= penable_d;
      PADDR <= paddr_d;
      PWRITE <= pwrite_d;
      PWDATA <= pwdata_d;
    end
endmodule

// File: tb/tb_ahb_to_apb_bridge_mp.sv
// tb_ahb_to_apb_bridge_mp: directed checks of the AHB to APB bridge (4-slave and 3-slave builds)
module tb_ahb_to_apb_bridge_mp;
  logic clk = 1'b0, hrstn, hsel, hsel3, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0] htrans;
  logic hready_out, hready_out3, penable, penable3, pwrite, pwrite3;
  logic [1:0] hresp, hresp3;
  logic [31:0] hrdata, hrdata3, paddr, paddr3, pwdata, pwdata3;
  logic [3:0] psel, pready, pslverr;
  logic [2:0] psel3;
  logic [127:0] prdata;
  int n_cmp = 0, n_err = 0, ws = 0;

  always #5 clk = ~clk;

  ahb_to_apb_bridge_mp u_dut (
    .HCLK(clk), .HRESETn(hrstn), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HWDATA(hwdata), .HREADY(hready_out), .HREADY_OUT(hready_out), .HRESP(hresp), .HRDATA(hrdata),
    .PSEL(psel), .PENABLE(penable), .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  ahb_to_apb_bridge_mp #(.NUM_SLAVES(3)) u_dut3 (
    .HCLK(clk), .HRESETn(hrstn), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HWDATA(hwdata), .HREADY(hready_out3), .HREADY_OUT(hready_out3), .HRESP(hresp3), .HRDATA(hrdata3),
    .PSEL(psel3), .PENABLE(penable3), .PADDR(paddr3), .PWRITE(pwrite3), .PWDATA(pwdata3),
    .PRDATA(prdata[95:0]), .PREADY(pready[2:0]), .PSLVERR(pslverr[2:0])
  );

  task automatic tick();
    if (!hready_out) ws++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w);
    hsel = 1'b1;
    haddr = a;
    hwrite = w;
    htrans = 2'b10;
    ws = 0;
    tick();
    hsel = 1'b0;
    htrans = 2'b00;
  endtask

  initial begin
    hrstn = 1'b0; hsel = 1'b0; hsel3 = 1'b0; haddr = '0; htrans = '0; hwrite = 1'b0; hwdata = '0;
    prdata = {32'hCAFEF00D, 32'h0, 32'h12345678, 32'h0BADF00D};
    pready = 4'hF; pslverr = 4'h0;
    tick(); tick();
    chk("rst_hready", 32'(hready_out), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    hrstn = 1'b1;
    tick(); tick();
    // BUSY transfer: zero-wait OKAY, no APB activity
    hsel = 1'b1; haddr = 32'h1000; htrans = 2'b01;
    tick();
    chk("busy_hready", 32'(hready_out), 32'd1);
    chk("busy_psel", 32'(psel), 32'd0);
    hsel = 1'b0; htrans = 2'b00;
    tick();
    // write DEADBEEF to slave 2, zero-wait slave
    addr_phase(32'h0000_2010, 1'b1);
    hwdata = 32'hDEADBEEF;
    chk("wr_hready_e0", 32'(hready_out), 32'd0);
    tick();
    chk("wr_psel", 32'(psel), 32'b0100);
    chk("wr_paddr", paddr, 32'h2010);
    chk("wr_pwrite", 32'(pwrite), 32'd1);
    chk("wr_pwdata", pwdata, 32'hDEADBEEF);
    chk("wr_penable_setup", 32'(penable), 32'd0);
    tick();
    chk("wr_penable_access", 32'(penable), 32'd1);
    tick();
    chk("wr_hready_done", 32'(hready_out), 32'd1);
    chk("wr_hresp", 32'(hresp), 32'd0);
    chk("wr_psel_off", 32'(psel), 32'd0);
    chk("wr_waits", ws, 32'd3);
    tick();
    // read slave 1 with two PREADY=0 ACCESS cycles
    pready[1] = 1'b0;
    addr_phase(32'h0000_1000, 1'b0);
    tick();
    tick();
    chk("rd_penable_a", 32'(penable), 32'd1);
    chk("rd_psel_a", 32'(psel), 32'b0010);
    tick();
    chk("rd_penable_b", 32'(penable), 32'd1);
    chk("rd_paddr_b", paddr, 32'h1000);
    chk("rd_pwrite_b", 32'(pwrite), 32'd0);
    tick();
    chk("rd_penable_c", 32'(penable), 32'd1);
    chk("rd_psel_c", 32'(psel), 32'b0010);
    chk("rd_hready_c", 32'(hready_out), 32'd0);
    pready[1] = 1'b1;
    tick();
    chk("rd_hready_done", 32'(hready_out), 32'd1);
    chk("rd_hrdata", hrdata, 32'h12345678);
    chk("rd_penable_off", 32'(penable), 32'd0);
    chk("rd_waits", ws, 32'd5);
    tick();
    // read slave 3 with PSLVERR: two-cycle ERROR, HRDATA unchanged
    pslverr[3] = 1'b1;
    addr_phase(32'h0000_3000, 1'b0);
    tick(); tick(); tick();
    chk("se_hready1", 32'(hready_out), 32'd0);
    chk("se_hresp1", 32'(hresp), 32'd1);
    chk("se_psel", 32'(psel), 32'd0);
    tick();
    chk("se_hready2", 32'(hready_out), 32'd1);
    chk("se_hresp2", 32'(hresp), 32'd1);
    tick();
    chk("se_hresp_idle", 32'(hresp), 32'd0);
    chk("se_hrdata", hrdata, 32'h12345678);
    pslverr[3] = 1'b0;
    // 3-slave build: index 3 decodes to an error, no PSEL
    hsel3 = 1'b1; haddr = 32'h3000; hwrite = 1'b0; htrans = 2'b10;
    tick();
    hsel3 = 1'b0; htrans = 2'b00;
    chk("de_hready1", 32'(hready_out3), 32'd0);
    chk("de_hresp1", 32'(hresp3), 32'd1);
    chk("de_psel1", 32'(psel3), 32'd0);
    tick();
    chk("de_hready2", 32'(hready_out3), 32'd1);
    chk("de_hresp2", 32'(hresp3), 32'd1);
    chk("de_psel2", 32'(psel3), 32'd0);
    tick();
    chk("de_hresp_idle", 32'(hresp3), 32'd0);
    // back-to-back write then read to slave 0
    ws = 0;
    hsel = 1'b1; haddr = 32'h0004; hwrite = 1'b1; htrans = 2'b10;
    tick();
    haddr = 32'h0008; hwrite = 1'b0; hwdata = 32'hA5A5A5A5;
    tick();
    chk("bb_wr_psel", 32'(psel), 32'b0001);
    chk("bb_wr_paddr", paddr, 32'h0004);
    chk("bb_wr_pwdata", pwdata, 32'hA5A5A5A5);
    chk("bb_hold1", 32'(hready_out), 32'd0);
    tick();
    chk("bb_hold2", 32'(hready_out), 32'd0);
    tick();
    chk("bb_wr_done", 32'(hready_out), 32'd1);
    chk("bb_gap1", 32'(psel), 32'd0);
    tick();
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hFFFFFFFF;
    chk("bb_gap2", 32'(psel), 32'd0);
    chk("bb_rd_accept", 32'(hready_out), 32'd0);
    tick();
    chk("bb_rd_psel", 32'(psel), 32'b0001);
    chk("bb_rd_paddr", paddr, 32'h0008);
    chk("bb_rd_pwrite", 32'(pwrite), 32'd0);
    chk("bb_rd_pwdata", pwdata, 32'hA5A5A5A5);
    tick(); tick();
    chk("bb_rd_done", 32'(hready_out), 32'd1);
    chk("bb_rd_hrdata", hrdata, 32'h0BADF00D);
    tick();
    // asynchronous reset during ACCESS
    pready[2] = 1'b0;
    addr_phase(32'h0000_2000, 1'b0);
    tick(); tick(); tick();
    chk("ar_penable_pre", 32'(penable), 32'd1);
    #2 hrstn = 1'b0;
    #1;
    chk("ar_psel", 32'(psel), 32'd0);
    chk("ar_penable", 32'(penable), 32'd0);
    chk("ar_hready", 32'(hready_out), 32'd1);
    chk("ar_hresp", 32'(hresp), 32'd0);
    chk("ar_hrdata", hrdata, 32'd0);
    chk("ar_paddr", paddr, 32'd0);
    chk("ar_pwdata", pwdata, 32'd0);
    hrstn = 1'b1;
    pready = 4'hF;
    tick(); tick();
    chk("ar_idle_psel", 32'(psel), 32'd0);
`ifdef APB_TIMEOUT_EN
    // PREADY stuck low: ERROR after 16 ACCESS cycles
    begin
      int n;
      pready[0] = 1'b0;
      addr_phase(32'h0000_0000, 1'b0);
      tick(); tick();
      n = 0;
      while (penable && n < 40) begin
        n++;
        tick();
      end
      chk("to_cycles", n, 32'd16);
      chk("to_hresp1", 32'(hresp), 32'd1);
      chk("to_hready1", 32'(hready_out), 32'd0);
      tick();
      chk("to_hready2", 32'(hready_out), 32'd1);
      tick();
      pready = 4'hF;
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ahb_to_apb_bridge_mp.md
# ahb_to_apb_bridge_mp

Parametrised AHB-Lite slave to APB3 master bridge driving NUM_SLAVES peripherals. It decodes a slave index from HADDR and runs a full APB SETUP/ACCESS sequence. PREADY wait states and PSLVERR are supported, and PSLVERR is mapped to a two-cycle AHB ERROR response. It replaces the single-slave, zero-wait bridge in the peripheral subsystem and sits between the AHB interconnect and the APB peripheral cluster.

## Interface
Parameters:
- ADDR_WIDTH, 32, AHB/APB address width
- DATA_WIDTH, 32, data width
- NUM_SLAVES, 4, APB slaves (1..16)
- SLAVE_AW, 12, address bits per slave region; index = HADDR[SLAVE_AW +: IDX_W], IDX_W = max(1, clog2(NUM_SLAVES))
- TIMEOUT_CYCLES, 16, ACCESS cycles before abort (APB_TIMEOUT_EN only)

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset, asynchronous, active-low
- HSEL  in  1  bridge selected
- HADDR  in  ADDR_WIDTH  address
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
- HWRITE  in  1  1 = write
- HWDATA  in  DATA_WIDTH  write data, valid in data phase
- HREADY  in  1  bus ready (address-phase qualifier)
- HREADY_OUT  out  1  bridge ready
- HRESP  out  2  00 OKAY, 01 ERROR
- HRDATA  out  DATA_WIDTH  read data
- PSEL  out  NUM_SLAVES  one-hot slave select
- PENABLE  out  1  ACCESS phase
- PADDR  out  ADDR_WIDTH  latched HADDR
- PWRITE  out  1  latched HWRITE
- PWDATA  out  DATA_WIDTH  latched HWDATA
- PRDATA  in  NUM_SLAVES*DATA_WIDTH  slave i read data at [i*DATA_WIDTH +: DATA_WIDTH]
- PREADY  in  NUM_SLAVES  per-slave ready
- PSLVERR  in  NUM_SLAVES  per-slave error

## Operation
- All outputs are registered.
- Reset values: HREADY_OUT=1, HRESP=00, HRDATA=0, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0. FSM resets to IDLE.
- Reset asserted mid-transfer aborts it immediately. No completion is signalled.
- FSM states: IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2.
- IDLE: HREADY_OUT=1, HRESP=00. Accept when HSEL && HREADY && HTRANS[1].
  - On accept, latch HADDR, HWRITE and the index, then go to LATCH with HREADY_OUT<=0.
  - If index >= NUM_SLAVES, go to ERR1 instead.
  - IDLE and BUSY transfers get a zero-wait OKAY response and cause no APB activity.
- LATCH: if the latched HWRITE is 1, capture PWDATA<=HWDATA; on reads PWDATA holds. Drive PADDR/PWRITE, PSEL[idx]<=1, go to SETUP.
- SETUP: PENABLE<=1, go to ACCESS.
- ACCESS: sample PREADY[idx].
  - PREADY=0: stay in ACCESS; PSEL, PENABLE, PADDR, PWRITE and PWDATA are stable.
  - PREADY=1 with PSLVERR=0: PSEL<=0, PENABLE<=0, HREADY_OUT<=1, HRESP=00; on a read, HRDATA<=PRDATA[idx]. Go to IDLE.
  - PREADY=1 with PSLVERR=1: PSEL<=0, PENABLE<=0, go to ERR1. HRDATA is unchanged.
- ERR1: HREADY_OUT=0, HRESP=01, go to ERR2.
- ERR2: HREADY_OUT=1, HRESP=01, go to IDLE. Any address phase presented during ERR2 is ignored, since the master cancels it per AHB.
- HRDATA holds its last value outside read completion.
- PSEL has at most one bit set at any time.
- PENABLE is only ever high when PSEL is nonzero.

## Timing
- Address phase accepted at edge E0:
  - E1: LATCH done.
  - E2: SETUP done (PSEL high E1–E3).
  - E3: PENABLE high E2–E3; PREADY sampled at E3.
  - HREADY_OUT is high after E3, so the AHB transfer completes at E4.
- A zero-wait APB slave costs 3 AHB wait states. Each PREADY=0 cycle adds 1.
- A decode error costs 2 cycles: HREADY_OUT=0 then 1, with HRESP=01 both cycles.
- A new transfer can be accepted on the completion edge (E4). Its PSEL rises at E5. There are no back-to-back APB transfers without an intervening IDLE cycle on PSEL.

## Configuration
- APB_TIMEOUT_EN defined:
  - A counter clears on SETUP→ACCESS and increments each ACCESS cycle with PREADY=0.
  - On reaching TIMEOUT_CYCLES, the bridge drops PSEL/PENABLE and goes to ERR1.
  - A write abandoned this way is not retried.
- APB_TIMEOUT_EN undefined: the counter is absent and ACCESS waits indefinitely for PREADY.

## Test plan
- Write 0xDEADBEEF to HADDR 0x0000_2010 (slave 2), PREADY tied high:
  - PSEL=4'b0100, PADDR=0x2010, PWRITE=1, PWDATA=0xDEADBEEF.
  - HREADY_OUT low 3 cycles; HRESP=OKAY.
- Read from slave 1 with PRDATA[1]=0x1234_5678 and PREADY low for 2 ACCESS cycles:
  - PENABLE high 3 cycles with APB signals stable.
  - HRDATA=0x12345678 at completion; 5 wait states total.
- Read from slave 3 with PSLVERR[3]=1 at PREADY: HRESP=01 for 2 cycles (HREADY_OUT 0 then 1), HRDATA unchanged.
- NUM_SLAVES=3, access HADDR 0x3000: no PSEL asserted, 2-cycle ERROR response.
- Back-to-back NONSEQ write then read to slave 0:
  - Second address is held by HREADY_OUT=0.
  - Two distinct APB transfers in order; PSEL low ≥1 cycle between them.
- HRESETn pulsed low during ACCESS: all outputs return to reset values asynchronously. With APB_TIMEOUT_EN and PREADY stuck low, ERROR appears after 16 ACCESS cycles.
